fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the decoder: owns the PC, issues word reads to

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_sync_fifo.sv | 85 ++++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;

  localparam int    FETCH_ADDR_WIDTH = 10;
  localparam int    FETCH_QDEPTH     = 2;
  localparam int    FETCH_MAX_OUTST  = 2;
  localparam word_t PC_STEP          = 32'd4;

  // One decoded-side slot: the fetched word and the PC it came from.
  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  // Sequential PC advance; wraps modulo 2^32.
  function automatic word_t pc_next(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush, simultaneous push/pop (also when full)
// and an occupancy count. Head is visible combinationally from storage.
module fetch_unit_sync_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  T                mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy; flush wins over everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only slots covered by count are ever observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Upstream credit accounting must never overflow this FIFO.
  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word reads,
// tags them with their PC, buffers returned words and hands them to decode.
// Redirects flush buffered work and discard responses still in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC   = 32'h0000_0000,
  parameter int    QDEPTH     = FETCH_QDEPTH,
  parameter int    MAX_OUTST  = FETCH_MAX_OUTST,
  parameter int    ADDR_WIDTH = FETCH_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  word_t                 imem_rsp_data,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output word_t                 dec_instr,
  output word_t                 dec_pc,
  output word_t                 dec_pc_plus4,
  input  logic                  redirect_valid,
  input  word_t                 redirect_pc,
  output logic                  fetch_fault
);

  localparam int FCW = $clog2(QDEPTH+1);
  localparam int OCW = $clog2(MAX_OUTST+1);
  localparam int SW  = FCW + 1;

  word_t          fetch_pc_q, fetch_pc_d;
  logic [OCW-1:0] outst_q, outst_d;
  logic [OCW-1:0] drop_cnt_q, drop_cnt_d;
  logic           fault_q, fault_d;

  logic           req_fire, rsp_accept, rsp_keep, dec_fire;
  logic [SW-1:0]  in_flight;

  fetch_entry_t   ififo_head, ififo_push_data;
  logic [FCW-1:0] ififo_count;
  logic           ififo_empty, ififo_full;
  word_t          tag_head;
  logic [OCW-1:0] tag_count;
  logic           tag_empty, tag_full;
  logic           unused_ok;

  // Issue gating: credits cover both buffered words and requests in flight.
  always_comb begin
    in_flight      = SW'(ififo_count) + SW'(outst_q);
    imem_req_valid = rst_n && !redirect_valid && !fault_q && (drop_cnt_q == '0) &&
                     (in_flight < SW'(QDEPTH)) && (outst_q < OCW'(MAX_OUTST));
  end

  assign imem_req_addr   = fetch_pc_q[ADDR_WIDTH+1:2];
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign rsp_accept      = rst_n && imem_rsp_valid;
  assign rsp_keep        = rsp_accept && !redirect_valid && (drop_cnt_q == '0);
  assign dec_valid       = rst_n && !ififo_empty;
  assign dec_fire        = dec_valid && dec_ready;
  assign dec_instr       = ififo_head.instr;
  assign dec_pc          = ififo_head.pc;
  assign dec_pc_plus4    = pc_next(ififo_head.pc);
  assign fetch_fault     = fault_q;
  assign ififo_push_data = '{instr: imem_rsp_data, pc: tag_head};
  assign unused_ok       = ^{tag_count, tag_empty, tag_full, ififo_full};

  // Next PC, in-flight and drop counters, and fault flag; redirect has top priority.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    fault_d    = fault_q;
    outst_d    = outst_q + OCW'(req_fire) - OCW'(rsp_accept && (outst_q != '0));
    if (redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old path.
      drop_cnt_d = outst_d;
      fetch_pc_d = redirect_pc;
      fault_d    = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (rsp_accept && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - OCW'(1);
      end
      if (req_fire) begin
        fetch_pc_d = pc_next(fetch_pc_q);
      end
    end
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
      fault_q    <= fault_d;
    end
  end

  fetch_unit_sync_fifo #(.T(word_t), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (rsp_keep),
    .head      (tag_head),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  fetch_unit_sync_fifo #(.T(fetch_entry_t), .DEPTH(QDEPTH)) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (ififo_push_data),
    .pop       (dec_fire),
    .head      (ififo_head),
    .count     (ififo_count),
    .empty     (ififo_empty),
    .full      (ififo_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder plus a scoreboard of
// expected {instr, pc} entries pushed at request issue and popped at decode.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          AW       = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data  = 32'h0;
  logic          dec_valid;
  logic          dec_ready;
  logic [31:0]   dec_instr, dec_pc, dec_pc_plus4;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          fetch_fault;

  logic          mem_hold = 1'b0;
  logic [AW-1:0] pend [$];
  logic [63:0]   sb   [$];
  logic [31:0]   exp_pc = RESET_PC;
  int            n_fire = 0;
  int            n_pop  = 0;
  int            n_cmp  = 0;
  int            n_err  = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(RESET_PC), .QDEPTH(2), .MAX_OUTST(2), .ADDR_WIDTH(AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_plus4   (dec_pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] idx);
    return {12'hA5C, 10'h000, idx};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_dec(input string tag, input int max);
    int i = 0;
    while (!dec_valid && i < max) begin
      @(negedge clk);
      i++;
    end
    check(tag, {31'b0, dec_valid}, 32'd1);
  endtask

  // Memory responder and scoreboard: samples handshakes on the active edge
  // (pre-update values) and drives the 1-cycle read response 1 ns later.
  initial begin : mem_and_monitor
    logic [63:0] e;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pend.delete();
        sb.delete();
        exp_pc = RESET_PC;
      end else begin
        if (dec_valid && dec_ready) begin
          n_pop++;
          check("dec_has_expected", {31'b0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("dec_instr", dec_instr, e[63:32]);
            check("dec_pc", dec_pc, e[31:0]);
            check("dec_pc_plus4", dec_pc_plus4, e[31:0] + 32'd4);
            $display("dec pc=0x%08h instr=0x%08h", dec_pc, dec_instr);
          end
        end
        if (imem_req_valid && imem_req_ready) begin
          n_fire++;
          check("req_addr", {22'b0, imem_req_addr}, {22'b0, exp_pc[AW+1:2]});
          pend.push_back(imem_req_addr);
          sb.push_back({mem_word(exp_pc[AW+1:2]), exp_pc});
          $display("req addr=0x%03h", imem_req_addr);
          exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) begin
          sb.delete();
          exp_pc = redirect_pc;
        end
      end
      #1;
      if (rst_n && !mem_hold && pend.size() != 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin : stimulus
    int f0;
    bit found;
    rst_n = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch from reset.
    wait_dec("t1_wait0", 10);
    check("t1_pc0", dec_pc, 32'h0);
    check("t1_instr0", dec_instr, mem_word(10'h0));
    @(negedge clk);
    wait_dec("t1_wait1", 10);
    check("t1_pc1", dec_pc, 32'h4);
    @(negedge clk);
    wait_dec("t1_wait2", 10);
    check("t1_pc2", dec_pc, 32'h8);
    check("t1_plus4", dec_pc_plus4, 32'hC);

    // Decoder stall: FIFO fills to exactly two and issue stops.
    dec_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_req_low", {31'b0, imem_req_valid}, 32'd0);
    check("t2_dec_valid", {31'b0, dec_valid}, 32'd1);
    check("t2_buffered", n_fire - n_pop, 32'd2);
    dec_ready = 1'b1;
    repeat (12) @(negedge clk);

    // Two outstanding requests are discarded by a redirect.
    mem_hold = 1'b1;
    repeat (6) @(negedge clk);
    check("t3_outst_limit", {31'b0, imem_req_valid}, 32'd0);
    check("t3_outst", n_fire - n_pop, 32'd2);
    check("t3_fifo_drained", {31'b0, dec_valid}, 32'd0);
    redirect(32'h0000_0100);
    mem_hold = 1'b0;
    check("t3_drop_blocks", {31'b0, imem_req_valid}, 32'd0);
    wait_dec("t3_wait", 20);
    check("t3_pc", dec_pc, 32'h0000_0100);
    check("t3_instr", dec_instr, mem_word(10'h040));

    // Redirect coinciding with a response and a decode handshake.
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = dec_valid && imem_rsp_valid;
    end
    check("t4_found", {31'b0, found}, 32'd1);
    redirect(32'h0000_0180);
    wait_dec("t4_wait", 20);
    check("t4_pc", dec_pc, 32'h0000_0180);

    // Misaligned target faults and halts; aligned target recovers.
    redirect(32'h0000_0102);
    check("t5_fault_set", {31'b0, fetch_fault}, 32'd1);
    check("t5_req_low", {31'b0, imem_req_valid}, 32'd0);
    f0 = n_fire;
    repeat (5) @(negedge clk);
    check("t5_no_fires", n_fire, f0);
    check("t5_dec_idle", {31'b0, dec_valid}, 32'd0);
    redirect(32'h0000_0200);
    check("t5_fault_clr", {31'b0, fetch_fault}, 32'd0);
    wait_dec("t5_wait", 20);
    check("t5_pc", dec_pc, 32'h0000_0200);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    wait_dec("wrap_wait0", 20);
    check("wrap_pc_hi", dec_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", dec_pc_plus4, 32'h0);
    check("wrap_instr", dec_instr, mem_word(10'h3FF));
    @(negedge clk);
    wait_dec("wrap_wait1", 20);
    check("wrap_pc_lo", dec_pc, 32'h0);

    // Mid-stream reset, taken while faulted.
    repeat (3) @(negedge clk);
    redirect(32'h0000_0306);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t6_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("t6_fault", {31'b0, fetch_fault}, 32'd0);
    rst_n = 1'b1;
    wait_dec("t6_wait", 20);
    check("t6_pc", dec_pc, RESET_PC);
    check("t6_instr", dec_instr, mem_word(10'h0));

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "timeout");
  end

endmodule
